// File: rtl/mdio_master.sv
// Clause-22 MDIO management initiator: divides clk_200m down to MDC and
// serialises read/write frames, sampling the responder late in the MDC high phase.
module mdio_master #(
    parameter int MDC_DIV = 40,
    parameter int PRE_LEN = 32
) (
    input  logic        clk_200m,
    input  logic        rst_200m,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
    output logic        busy,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        rd_ta_err,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oen,
    input  logic        mdio_in,
    output logic [2:0]  fsm_state
);
    localparam int PW = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(MDC_DIV - 1);
    localparam logic [5:0] PRE_LAST = (PRE_LEN > 0) ? 6'(PRE_LEN - 1) : 6'd0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_HDR  = 3'd2,
        ST_TA   = 3'd3,
        ST_DATA = 3'd4,
        ST_END  = 3'd5
    } state_t;

    state_t        state;
    logic [PW-1:0] ph;
    logic [5:0]    bit_cnt;
    logic [31:0]   frame;
    logic          wr;
    logic [15:0]   rd_shift;
    logic          ta_err;
    logic          mdio_meta;
    logic          mdio_sync;
    logic          bit_end;
    logic          tail_out;

    assign fsm_state = state;
    assign busy      = ~cmd_ready;
    // Handshake: a command transfers on a cycle where cmd_valid & cmd_ready are
    // both high; cmd_ready is high only in IDLE, so cmd_valid while busy is ignored.
    assign bit_end   = mdc && (ph == PH_LAST);
    // After the header, reads release the line; writes keep shifting the frame.
    assign tail_out  = wr ? frame[30] : 1'b1;

    always_ff @(posedge clk_200m) begin
        if (rst_200m) begin
            mdio_meta <= 1'b1;
            mdio_sync <= 1'b1;
        end else begin
            mdio_meta <= mdio_in;
            mdio_sync <= mdio_meta;
        end
    end

    always_ff @(posedge clk_200m) begin
        if (rst_200m) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            ph        <= '0;
            bit_cnt   <= '0;
            mdc       <= 1'b0;
            mdio_out  <= 1'b1;
            mdio_oen  <= 1'b1;
            frame     <= '0;
            wr        <= 1'b0;
            rd_shift  <= '0;
            ta_err    <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_ta_err <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (state == ST_IDLE) begin
                mdc <= 1'b0;
                ph  <= '0;
                if (cmd_valid && cmd_ready) begin
                    cmd_ready <= 1'b0;
                    wr        <= cmd_write;
                    frame     <= {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phyad,
                                  cmd_regad, 2'b10, cmd_wdata};
                    mdio_oen  <= 1'b0;
                    if (PRE_LEN > 0) begin
                        state    <= ST_PRE;
                        bit_cnt  <= PRE_LAST;
                        mdio_out <= 1'b1;
                    end else begin
                        state    <= ST_HDR;
                        bit_cnt  <= 6'd13;
                        mdio_out <= 1'b0;
                    end
                end else begin
                    cmd_ready <= 1'b1;
                end
            end else begin
                if (ph == PH_LAST) begin
                    ph  <= '0;
                    mdc <= ~mdc;
                end else begin
                    ph <= ph + 1'b1;
                end

                // Bit boundary: sample the responder, then present the next bit.
                if (bit_end) begin
                    case (state)
                        ST_PRE: begin
                            if (bit_cnt != 6'd0) begin
                                bit_cnt <= bit_cnt - 6'd1;
                            end else begin
                                state    <= ST_HDR;
                                bit_cnt  <= 6'd13;
                                mdio_out <= frame[31];
                            end
                        end
                        ST_HDR: begin
                            frame <= {frame[30:0], 1'b0};
                            if (bit_cnt != 6'd0) begin
                                bit_cnt  <= bit_cnt - 6'd1;
                                mdio_out <= frame[30];
                            end else begin
                                state    <= ST_TA;
                                bit_cnt  <= 6'd1;
                                mdio_out <= tail_out;
                                mdio_oen <= ~wr;
                            end
                        end
                        ST_TA: begin
                            frame    <= {frame[30:0], 1'b0};
                            mdio_out <= tail_out;
                            if (bit_cnt != 6'd0) begin
                                bit_cnt <= bit_cnt - 6'd1;
                            end else begin
                                ta_err  <= mdio_sync;
                                state   <= ST_DATA;
                                bit_cnt <= 6'd15;
                            end
                        end
                        ST_DATA: begin
                            frame    <= {frame[30:0], 1'b0};
                            rd_shift <= {rd_shift[14:0], mdio_sync};
                            if (bit_cnt != 6'd0) begin
                                bit_cnt  <= bit_cnt - 6'd1;
                                mdio_out <= tail_out;
                            end else begin
                                state    <= ST_END;
                                bit_cnt  <= 6'd0;
                                mdio_out <= 1'b1;
                                mdio_oen <= 1'b1;
                            end
                        end
                        ST_END: begin
                            state     <= ST_IDLE;
                            cmd_ready <= 1'b1;
                            mdio_out  <= 1'b1;
                            mdio_oen  <= 1'b1;
                            if (!wr) begin
                                rd_valid  <= 1'b1;
                                rd_data   <= rd_shift;
                                rd_ta_err <= ta_err;
                            end
                        end
                        default: begin
                            state    <= ST_IDLE;
                            mdio_out <= 1'b1;
                            mdio_oen <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end
endmodule
